pulse_spacer: RTL and testbench

- clk1-domain stage directly upstream of the toggle-based pulse synchronizer; its pulse_out drives the synchronizer's pulse_in.
- Accepts bursty single-cycle event requests and re-emits them as isolated one-cycle pulses at least MIN_GAP clk1 cycles apart.
- The spacing guarantees the slow clk2 side never misses a toggle. Backlogged events are held in a saturating pending counter; drops are flagged.

---
 rtl/pulse_cdc_pkg.sv | 10 +
 rtl/pulse_spacer.sv | 48 ++++
 tb/tb_pulse_spacer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pulse_cdc_pkg.sv
// pulse_cdc_pkg: constants and helpers shared by the pulse spacer and the synchronizer wrapper
package pulse_cdc_pkg;
  localparam int MIN_GAP_DEF = 6;
  function automatic int gap_w(input int min_gap);
    return (min_gap > 1) ? $clog2(min_gap) : 1;
  endfunction
  function automatic bit min_gap_ok(input int min_gap);
    return min_gap >= 2;
  endfunction
endpackage

// File: rtl/pulse_spacer.sv
// pulse_spacer: re-emits bursty events as one-cycle pulses at least MIN_GAP clk1 cycles apart
module pulse_spacer import pulse_cdc_pkg::*; #(
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int CNT_W = 4
) (
  input  logic             clk1,
  input  logic             rst1,
  input  logic             evt_in,
  input  logic             clear,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);
  localparam int GW = gap_w(MIN_GAP);
  if (!min_gap_ok(MIN_GAP)) begin : g_bad_gap
    $error("pulse_spacer: MIN_GAP must be at least 2");
  end
  logic [CNT_W-1:0] p_q, p_d;
  logic [GW-1:0] g_q, g_d;
  logic pulse_q, pulse_d, ovf_q, ovf_d, issue, drop;
  // clear suppresses issue but lets the gap timer keep counting down
  always_comb begin
    issue = !clear && g_q == '0 && (p_q != '0 || evt_in);
    drop = !clear && evt_in && !issue && (&p_q);
    pulse_d = issue;
    g_d = issue ? GW'(MIN_GAP - 1) : g_q - GW'(g_q != '0);
    p_d = clear ? '0 : drop ? p_q : p_q + CNT_W'(evt_in) - CNT_W'(issue);
    ovf_d = !clear && (ovf_q || drop);
  end
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      p_q <= '0;
      g_q <= '0;
      pulse_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      p_q <= p_d;
      g_q <= g_d;
      pulse_q <= pulse_d;
      ovf_q <= ovf_d;
    end
  end
  assign pulse_out = pulse_q;
  assign pending = p_q;
  assign busy = (p_q != '0) || (g_q != '0);
  assign overflow = ovf_q;
endmodule

// File: tb/tb_pulse_spacer.sv
// tb_pulse_spacer: directed and random checks of pulse_spacer against a timestamp-based model
module tb_pulse_spacer;
  localparam int MIN_GAP = 6;
  localparam int CNT_W = 4;
  localparam int PMAX = 15;
  logic clk1 = 1'b0, clk2 = 1'b0, rst1 = 1'b0, evt_in = 1'b0, clear = 1'b0;
  logic pulse_out, busy, overflow;
  logic [CNT_W-1:0] pending;
  int n_chk = 0, n_fail = 0;
  int e = 0, m_pend = 0, m_last = -1000, last_dut = -1000, pmax_seen = 0;
  bit m_pulse = 0, m_ovf = 0;
  int q[$];
  logic t1 = 1'b0;
  logic [2:0] s2 = '0;
  int n1 = 0, n2 = 0;

  pulse_spacer #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
    .clk1(clk1), .rst1(rst1), .evt_in(evt_in), .clear(clear),
    .pulse_out(pulse_out), .pending(pending), .busy(busy), .overflow(overflow)
  );

  always #5 clk1 = ~clk1;
  always #15 clk2 = ~clk2;

  // toggle synchronizer into a clk1/3 domain, counting pulses on both sides
  always @(negedge clk1) if (pulse_out === 1'b1) begin
    t1 <= ~t1;
    n1 <= n1 + 1;
  end
  always @(posedge clk2) begin
    s2 <= {s2[1:0], t1};
    if (s2[2] ^ s2[1]) n2 <= n2 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, e);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_last = -1000; m_pulse = 0; m_ovf = 0; last_dut = -1000; e = 0;
  endtask

  task automatic step(input logic ev, input logic cl);
    int tot;
    evt_in = ev; clear = cl;
    @(posedge clk1);
    e++;
    if (cl) begin
      m_pend = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      m_pulse = (e - m_last >= MIN_GAP) && (m_pend > 0 || ev);
      if (m_pulse) m_last = e;
      tot = m_pend + int'(ev) - int'(m_pulse);
      if (tot > PMAX) begin m_ovf = 1; tot = PMAX; end
      m_pend = tot;
    end
    #1;
    chk("pulse_out", pulse_out, m_pulse);
    chk("pending", pending, m_pend);
    chk("busy", busy, (m_pend != 0 || e - m_last <= MIN_GAP - 2));
    chk("overflow", overflow, m_ovf);
    if (pulse_out === 1'b1) begin
      chk("spacing_ok", (e - last_dut >= MIN_GAP), 1);
      last_dut = e;
      q.push_back(e);
    end
    if (int'(pending) > pmax_seen) pmax_seen = int'(pending);
  endtask

  task automatic drain();
    int k = 0;
    while (busy === 1'b1 && k < 400) begin step(0, 0); k++; end
    chk("drain_done", busy, 0);
  endtask

  initial begin
    int b;
    #1 rst1 = 1'b1;
    #1;
    chk("rst_pulse", pulse_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk1); @(posedge clk1); #1 rst1 = 1'b0;
    model_reset();
    repeat (3) step(0, 0);

    // single event
    b = e + 1;
    step(1, 0);
    chk("single_pulse_hi", pulse_out, 1);
    step(0, 0);
    chk("single_pulse_lo", pulse_out, 0);
    repeat (3) step(0, 0);
    chk("single_busy_last", busy, 1);
    step(0, 0);
    chk("single_busy_fall", busy, 0);
    chk("single_fall_edge", e - b, 5);

    // burst of four
    repeat (2) step(0, 0);
    q.delete(); pmax_seen = 0;
    b = e + 1;
    repeat (4) step(1, 0);
    drain();
    chk("burst_count", q.size(), 4);
    if (q.size() == 4) for (int i = 0; i < 4; i++) chk("burst_edge", q[i] - b, 6 * i);
    chk("burst_peak", pmax_seen, 3);
    chk("burst_busy_fall", e - b, 23);

    // saturation
    q.delete();
    for (int k = 0; k < 20; k++) begin
      step(1, 0);
      if (k == 17) chk("sat_pending15", pending, 15);
      if (k == 18) chk("sat_ovf_before", overflow, 0);
      if (k == 19) chk("sat_ovf_after", overflow, 1);
    end
    drain();
    chk("sat_pulses", q.size(), 19);
    chk("sat_pending_end", pending, 0);
    chk("sat_ovf_sticky", overflow, 1);

    // clear with backlog 7 and two gap cycles left
    repeat (9) step(1, 0);
    step(0, 0);
    chk("clr_pre_pending", pending, 7);
    step(1, 1);
    chk("clr_pending", pending, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_no_pulse", pulse_out, 0);
    chk("clr_gap_busy", busy, 1);
    step(0, 0);
    chk("clr_gap_done", busy, 0);
    step(1, 0);
    chk("clr_fresh_pulse", pulse_out, 1);
    drain();

    // asynchronous reset mid-cycle with P=5, G=3
    repeat (7) step(1, 0);
    repeat (2) step(0, 0);
    chk("ar_pre_pending", pending, 5);
    chk("ar_pre_busy", busy, 1);
    evt_in = 1'b0;
    #2 rst1 = 1'b1;
    #1;
    chk("ar_pulse", pulse_out, 0);
    chk("ar_pending", pending, 0);
    chk("ar_busy", busy, 0);
    chk("ar_overflow", overflow, 0);
    @(posedge clk1); @(posedge clk1); #1 rst1 = 1'b0;
    model_reset();
    repeat (5) step(0, 0);
    step(1, 0);
    chk("ar_first_evt", pulse_out, 1);
    drain();

    // random traffic
    for (int k = 0; k < 1000; k++) step($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    step(0, 0);
    drain();
    repeat (20) @(posedge clk1);
    chk("sync_pulse_count", n2, n1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
